frame_timing_gen: RTL and testbench
===================================

Name: frame_timing_gen

Overview:
Upstream timing source for frame_pattern_gen. Generates Camera-Link-style FVAL/LVAL/DVAL framing, plus the single-cycle lval_negedge and fval_posedge strobes that the pattern generator consumes directly. Also outputs pixel/line/frame counters so downstream stages need no edge detection of their own.

Parameters:
DVAL_HIGH, 640, active pixels per line (dval-high cycles per line); must be ≥1
ROW_COUNT, 480, active lines per frame; must be ≥1
H_GAP, 16, lval-low cycles before every line and after the last line (fval high); must be ≥1
V_GAP, 32, fval-low cycles between frames; must be ≥1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  run request; sampled in IDLE and at frame end
fval  output  1  frame valid
lval  output  1  line valid
dval  output  1  data valid (equals lval in this block)
fval_posedge  output  1  one-cycle strobe: first cycle fval is high
lval_negedge  output  1  one-cycle strobe: first cycle lval is low after a line
pix_x  output  16  active pixel index, 0..DVAL_HIGH-1 while dval, else 0
line_y  output  16  current line index 0..ROW_COUNT-1
frame_count  output  16  completed-frame-start counter, wraps
busy  output  1  high in any state except IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- All outputs are registered. On rst: state=IDLE; fval, lval, dval, strobes, busy=0; pix_x, line_y, frame_count=0. Reset mid-frame aborts immediately. No strobes are emitted on the cycle after reset.
- FSM states: IDLE, FRAME_GAP, LINE_GAP, LINE_ACTIVE, FRAME_TAIL. A single 16-bit cycle counter cnt times each state.
- IDLE: all outputs low. If enable=1, go to FRAME_GAP on the next cycle.
- FRAME_GAP: fval=0 for exactly V_GAP cycles, then LINE_GAP.
- LINE_GAP: fval=1, lval=0 for exactly H_GAP cycles, then LINE_ACTIVE.
  - fval_posedge=1 only in the first LINE_GAP cycle of a frame, i.e. line_y=0.
  - frame_count increments in that same cycle, 0xFFFF→0.
- LINE_ACTIVE: fval=lval=dval=1 for exactly DVAL_HIGH cycles. pix_x counts 0,1,…,DVAL_HIGH-1.
  - Exit when line_y<ROW_COUNT-1: go to LINE_GAP and increment line_y.
  - Exit on the last line: go to FRAME_TAIL.
- lval_negedge=1 in the first cycle after every LINE_ACTIVE, i.e. the first cycle of LINE_GAP or FRAME_TAIL. Exactly ROW_COUNT pulses per frame.
- FRAME_TAIL: fval=1, lval=0 for exactly H_GAP cycles. Then:
  - enable=1 → FRAME_GAP, line_y←0.
  - enable=0 → IDLE, line_y←0.
- enable deasserted mid-frame does not truncate the frame; it takes effect only at the FRAME_TAIL exit.
- line_y holds its value during gaps; it is 0 in IDLE and FRAME_GAP.
- Frame period (continuous enable) = V_GAP + ROW_COUNT*(H_GAP+DVAL_HIGH) + H_GAP cycles.
- fval_posedge and lval_negedge are never high together. fval_posedge is high only in the first LINE_GAP cycle; lval_negedge is never high on line 0's first gap cycle.
- Counters are 16 bits; the parameters must fit in 16 bits.

Test Plan:
1. Use DVAL_HIGH=8, ROW_COUNT=4, H_GAP=3, V_GAP=5; rst, then enable=1 constant → fval rises 5 cycles after FRAME_GAP entry. Frame period is 52 cycles. Each frame has 4 lval pulses of 8 cycles, 4 lval_negedge and 1 fval_posedge. pix_x runs 0..7 per line.
2. Same params, check per-frame counts → 32 dval cycles per frame. line_y runs 0,1,2,3. fval stays high for 47 cycles.
3. Deassert enable during line 1 of frame 0 → frame completes with all 4 lines. After FRAME_TAIL go to IDLE: busy=0, no further fval.
4. Assert rst during LINE_ACTIVE of line 2 → next cycle all outputs 0 and frame_count=0. Re-enable → full, clean frame with fval_posedge.
5. Force frame_count near wrap (run 65536 frames with minimal params, or reach it via backdoor) → count goes 0xFFFF→0x0000 on fval_posedge.
6. Connect to frame_pattern_gen (sel=3'b011, DVAL_HIGH=8, ROW_COUNT=8) → checker output alternates every pixel and every line. Counters reset on each lval_negedge and each fval_posedge.

Source files
------------

// File: rtl/frame_timing_gen.sv
// Camera-Link style FVAL/LVAL/DVAL frame timing source with pixel/line/frame
// counters and single-cycle fval_posedge / lval_negedge strobes; all outputs registered.
module frame_timing_gen #(
    parameter int DVAL_HIGH = 640,
    parameter int ROW_COUNT = 480,
    parameter int H_GAP     = 16,
    parameter int V_GAP     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        fval,
    output logic        lval,
    output logic        dval,
    output logic        fval_posedge,
    output logic        lval_negedge,
    output logic [15:0] pix_x,
    output logic [15:0] line_y,
    output logic [15:0] frame_count,
    output logic        busy
);

    localparam logic [15:0] DVAL_LAST = 16'(DVAL_HIGH - 1);
    localparam logic [15:0] ROW_LAST  = 16'(ROW_COUNT - 1);
    localparam logic [15:0] HGAP_LAST = 16'(H_GAP - 1);
    localparam logic [15:0] VGAP_LAST = 16'(V_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAME_GAP,
        S_LINE_GAP,
        S_LINE_ACTIVE,
        S_FRAME_TAIL
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_cnt;
    logic [15:0] w_next_cnt;
    logic [15:0] r_line_y;
    logic [15:0] w_next_line_y;
    logic [15:0] r_frame_count;
    logic [15:0] w_next_frame_count;
    logic [15:0] r_pix_x;
    logic [15:0] w_next_pix_x;
    logic        r_fval;
    logic        r_lval;
    logic        r_fval_posedge;
    logic        r_lval_negedge;
    logic        r_busy;
    logic        w_next_fval;
    logic        w_next_lval;
    logic        w_next_fval_posedge;
    logic        w_next_lval_negedge;
    logic        w_next_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_line_y       <= '0;
            r_frame_count  <= '0;
            r_pix_x        <= '0;
            r_fval         <= 1'b0;
            r_lval         <= 1'b0;
            r_fval_posedge <= 1'b0;
            r_lval_negedge <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_cnt          <= w_next_cnt;
            r_line_y       <= w_next_line_y;
            r_frame_count  <= w_next_frame_count;
            r_pix_x        <= w_next_pix_x;
            r_fval         <= w_next_fval;
            r_lval         <= w_next_lval;
            r_fval_posedge <= w_next_fval_posedge;
            r_lval_negedge <= w_next_lval_negedge;
            r_busy         <= w_next_busy;
        end
    end

    // Next state and counters; cnt restarts at 0 on every state change.
    always_comb begin
        w_next_state       = r_state;
        w_next_cnt         = r_cnt + 16'd1;
        w_next_line_y      = r_line_y;
        w_next_frame_count = r_frame_count;

        case (r_state)
            S_IDLE: begin
                w_next_cnt    = '0;
                w_next_line_y = '0;
                if (enable) begin
                    w_next_state = S_FRAME_GAP;
                end
            end
            S_FRAME_GAP: begin
                if (r_cnt == VGAP_LAST) begin
                    w_next_state       = S_LINE_GAP;
                    w_next_cnt         = '0;
                    w_next_frame_count = r_frame_count + 16'd1;
                end
            end
            S_LINE_GAP: begin
                if (r_cnt == HGAP_LAST) begin
                    w_next_state = S_LINE_ACTIVE;
                    w_next_cnt   = '0;
                end
            end
            S_LINE_ACTIVE: begin
                if (r_cnt == DVAL_LAST) begin
                    w_next_cnt = '0;
                    if (r_line_y == ROW_LAST) begin
                        w_next_state = S_FRAME_TAIL;
                    end else begin
                        w_next_state  = S_LINE_GAP;
                        w_next_line_y = r_line_y + 16'd1;
                    end
                end
            end
            S_FRAME_TAIL: begin
                if (r_cnt == HGAP_LAST) begin
                    w_next_cnt    = '0;
                    w_next_line_y = '0;
                    w_next_state  = enable ? S_FRAME_GAP : S_IDLE;
                end
            end
            default: begin
                w_next_state  = S_IDLE;
                w_next_cnt    = '0;
                w_next_line_y = '0;
            end
        endcase
    end

    // Output decode looks at the next state so the registered outputs line up with r_state.
    always_comb begin
        w_next_fval         = (w_next_state == S_LINE_GAP) ||
                              (w_next_state == S_LINE_ACTIVE) ||
                              (w_next_state == S_FRAME_TAIL);
        w_next_lval         = (w_next_state == S_LINE_ACTIVE);
        w_next_busy         = (w_next_state != S_IDLE);
        w_next_pix_x        = (w_next_state == S_LINE_ACTIVE) ? w_next_cnt : 16'd0;
        w_next_fval_posedge = (r_state == S_FRAME_GAP) && (w_next_state == S_LINE_GAP);
        w_next_lval_negedge = (r_state == S_LINE_ACTIVE) && (w_next_state != S_LINE_ACTIVE);
    end

    assign fval         = r_fval;
    assign lval         = r_lval;
    assign dval         = r_lval;
    assign fval_posedge = r_fval_posedge;
    assign lval_negedge = r_lval_negedge;
    assign pix_x        = r_pix_x;
    assign line_y       = r_line_y;
    assign frame_count  = r_frame_count;
    assign busy         = r_busy;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Scoreboard bench for frame_timing_gen: expected per-cycle output vectors are
// generated from the frame structure and compared against the DUT every cycle.
module tb_frame_timing_gen;

    localparam int DH = 8;
    localparam int RC = 4;
    localparam int HG = 3;
    localparam int VG = 5;
    localparam int FP = VG + RC * (HG + DH) + HG;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fval;
    logic        lval;
    logic        dval;
    logic        fval_posedge;
    logic        lval_negedge;
    logic [15:0] pix_x;
    logic [15:0] line_y;
    logic [15:0] frame_count;
    logic        busy;

    frame_timing_gen #(
        .DVAL_HIGH(DH),
        .ROW_COUNT(RC),
        .H_GAP    (HG),
        .V_GAP    (VG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fval        (fval),
        .lval        (lval),
        .dval        (dval),
        .fval_posedge(fval_posedge),
        .lval_negedge(lval_negedge),
        .pix_x       (pix_x),
        .line_y      (line_y),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fval;
        logic        lval;
        logic        fpos;
        logic        lneg;
        logic        busy;
        logic [15:0] pix;
        logic [15:0] line;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_fc;
    int          cnt_fval;
    int          cnt_dval;
    int          cnt_lneg;
    int          cnt_fpos;
    int          first_fval_idx;
    int          cyc_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic l, input logic fp, input logic ln,
                                input logic b, input int px, input int ly, input logic [15:0] fc);
        exp_t e;
        e.fval = f;
        e.lval = l;
        e.fpos = fp;
        e.lneg = ln;
        e.busy = b;
        e.pix  = 16'(px);
        e.line = 16'(ly);
        e.fc   = fc;
        return e;
    endfunction

    task automatic push_frame();
        for (int i = 0; i < VG; i++) sb_q.push_back(mk(0, 0, 0, 0, 1, 0, 0, m_fc));
        m_fc = m_fc + 16'd1;
        for (int y = 0; y < RC; y++) begin
            for (int i = 0; i < HG; i++)
                sb_q.push_back(mk(1, 0, (y == 0 && i == 0), (y != 0 && i == 0), 1, 0, y, m_fc));
            for (int i = 0; i < DH; i++)
                sb_q.push_back(mk(1, 1, 0, 0, 1, i, y, m_fc));
        end
        for (int i = 0; i < HG; i++) sb_q.push_back(mk(1, 0, 0, (i == 0), 1, 0, RC - 1, m_fc));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, m_fc));
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("fval", 32'(fval), 32'(e.fval));
            check("lval", 32'(lval), 32'(e.lval));
            check("dval", 32'(dval), 32'(e.lval));
            check("fval_posedge", 32'(fval_posedge), 32'(e.fpos));
            check("lval_negedge", 32'(lval_negedge), 32'(e.lneg));
            check("busy", 32'(busy), 32'(e.busy));
            check("pix_x", 32'(pix_x), 32'(e.pix));
            check("line_y", 32'(line_y), 32'(e.line));
            check("frame_count", 32'(frame_count), 32'(e.fc));
        end
        if (fval) cnt_fval++;
        if (dval) cnt_dval++;
        if (lval_negedge) cnt_lneg++;
        if (fval_posedge) cnt_fpos++;
        if (fval && first_fval_idx < 0) first_fval_idx = cyc_idx;
        cyc_idx++;
    endtask

    // Starts from IDLE, runs n frames, drops enable during line 1 of the last frame.
    task automatic run_frames(input int n);
        cnt_fval       = 0;
        cnt_dval       = 0;
        cnt_lneg       = 0;
        cnt_fpos       = 0;
        first_fval_idx = -1;
        cyc_idx        = 0;
        enable         = 1'b1;
        for (int f = 0; f < n; f++) push_frame();
        push_idle(4);
        for (int c = 0; c < n * FP + 4; c++) begin
            step();
            if (c == (n - 1) * FP + 20) enable = 1'b0;
        end
        check("fval_rise_idx", 32'(first_fval_idx), 32'(VG));
        check("fval_cycles", 32'(cnt_fval), 32'(n * 47));
        check("dval_cycles", 32'(cnt_dval), 32'(n * 32));
        check("lval_negedge_cnt", 32'(cnt_lneg), 32'(n * 4));
        check("fval_posedge_cnt", 32'(cnt_fpos), 32'(n));
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        m_fc   = 16'd0;
        cyc_idx = 0;
        first_fval_idx = -1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fval", 32'(fval), 32'd0);
        check("rst_lval", 32'(lval), 32'd0);
        check("rst_dval", 32'(dval), 32'd0);
        check("rst_fpos", 32'(fval_posedge), 32'd0);
        check("rst_lneg", 32'(lval_negedge), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix_x", 32'(pix_x), 32'd0);
        check("rst_line_y", 32'(line_y), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        rst = 1'b0;

        // Two back-to-back frames, enable dropped mid second frame.
        run_frames(2);

        // Reset during line 2 active, then a clean frame.
        enable = 1'b1;
        push_frame();
        for (int c = 0; c < 32; c++) step();
        check("pre_rst_line_y", 32'(line_y), 32'd2);
        rst = 1'b1;
        sb_q.delete();
        m_fc = 16'd0;
        push_idle(1);
        step();
        rst = 1'b0;
        run_frames(1);

        // frame_count wrap via backdoor preset while idle.
        force dut.r_frame_count = 16'hFFFE;
        m_fc = 16'hFFFE;
        push_idle(1);
        step();
        release dut.r_frame_count;
        run_frames(2);
        check("wrap_final_count", 32'(frame_count), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
